ps2_key_event_hub: RTL



---
 rtl/ps2_key_event_hub.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_hub.sv
// PS/2 keyboard front-end: decodes scan bytes into make/break events with an
// extended-key flag, buffers them in a FWFT FIFO, and shows a rolling history
// of raw bytes on active-low seven-segment digits.

// Hex nibble to active-low gfedcba segment pattern.
module ps2_hex7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // Pure lookup, one pattern per nibble value.
  always_comb begin
    seg_o = 7'b1000000;
    case (nib_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1000000;
    endcase
  end
endmodule

module ps2_key_event_hub #(
  parameter int DEPTH      = 8,
  parameter int NUM_DIGITS = 8
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      ps2_key_pressed,
  input  logic [7:0]                ps2_key_data,
  input  logic                      pop,
  output logic                      evt_valid,
  output logic [9:0]                evt_data,
  output logic [$clog2(DEPTH):0]    evt_count,
  output logic                      overflow,
  input  logic                      clear_overflow,
  output logic [7*NUM_DIGITS-1:0]   seg_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = NUM_DIGITS / 2;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_e;

  state_e state_q, state_d;
  logic       emit;
  logic [9:0] emit_evt;

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, push_ok, pop_ok, drop;

  logic [NB-1:0][7:0]         hist_q, hist_d;
  logic [NUM_DIGITS-1:0][6:0] seg_q, seg_d;

  // Decoder state register; reset discards any partial prefix.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Prefix tracking and event emission; only strobed bytes advance the FSM.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_evt = '0;
    if (ps2_key_pressed) begin
      case (state_q)
        IDLE: begin
          if (ps2_key_data == BYTE_E0)      state_d = GOT_E0;
          else if (ps2_key_data == BYTE_F0) state_d = GOT_F0;
          else begin
            emit     = 1'b1;
            emit_evt = {2'b00, ps2_key_data};
          end
        end
        GOT_E0: begin
          if (ps2_key_data == BYTE_E0)      state_d = GOT_E0;
          else if (ps2_key_data == BYTE_F0) state_d = GOT_E0F0;
          else begin
            emit     = 1'b1;
            emit_evt = {2'b10, ps2_key_data};
            state_d  = IDLE;
          end
        end
        GOT_F0: begin
          if (ps2_key_data == BYTE_F0)      state_d = GOT_F0;
          else if (ps2_key_data == BYTE_E0) state_d = GOT_E0F0;
          else begin
            emit     = 1'b1;
            emit_evt = {2'b01, ps2_key_data};
            state_d  = IDLE;
          end
        end
        GOT_E0F0: begin
          if (ps2_key_data == BYTE_E0 || ps2_key_data == BYTE_F0) state_d = GOT_E0F0;
          else begin
            emit     = 1'b1;
            emit_evt = {2'b11, ps2_key_data};
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO succeeds.
  assign full       = (count_q == CW'(DEPTH));
  assign pop_ok     = pop && (count_q != '0);
  assign push_ok    = emit && (!full || pop_ok);
  assign drop       = emit && full && !pop_ok;
  assign count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
  assign overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);

  // FIFO storage and pointers; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= emit_evt;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign evt_count = count_q;
  assign overflow  = overflow_q;

  // Every strobed byte, prefixes included, shifts in at index 0.
  always_comb begin
    hist_d = hist_q;
    if (ps2_key_pressed) begin
      hist_d[0] = ps2_key_data;
      for (int k = 1; k < NB; k++) hist_d[k] = hist_q[k-1];
    end
  end

  // Digits decode the next history so the display lags the strobe by one edge.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic [3:0] nib;
    assign nib = (i % 2 == 1) ? hist_d[i/2][7:4] : hist_d[i/2][3:0];
    ps2_hex7seg u_hex (.nib_i(nib), .seg_o(seg_d[i]));
  end

  // History and display registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hist_q <= '0;
      seg_q  <= {NUM_DIGITS{7'b1000000}};
    end else begin
      hist_q <= hist_d;
      seg_q  <= seg_d;
    end
  end

  assign seg_out = seg_q;
endmodule
